// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer: counter
// encodings, the per-entry record and PC index/tag extraction.
package btb_pkg;

    localparam int ENTRIES_DEFAULT = 16;

    // 2-bit direction counter; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // Tag is held at its widest possible size (30 bits, ENTRIES=1); upper
    // bits stay zero for larger tables and drop out in synthesis.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        ctr_e        ctr;
    } btb_entry_t;

    // Word index into the table: pc[idx_w+1:2].
    function automatic logic [7:0] pc_index(input logic [31:0] pc, input int idx_w);
        return 8'((pc >> 2) & ((32'd1 << idx_w) - 32'd1));
    endfunction

    // Tag: everything above the index, zero-extended to 30 bits.
    function automatic logic [29:0] pc_tag(input logic [31:0] pc, input int idx_w);
        return 30'(pc >> (idx_w + 2));
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Combinational next-state of a 2-bit saturating direction counter.
module sat_counter2
    import btb_pkg::*;
(
    input  ctr_e ctr,
    input  logic taken,
    output ctr_e ctr_next
);

    // Step toward strong-taken on taken, toward strong-not-taken otherwise.
    always_comb begin
        ctr_next = ctr;
        case (ctr)
            CTR_SNT: ctr_next = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: ctr_next = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  ctr_next = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  ctr_next = taken ? CTR_ST  : CTR_WT;
            default: ctr_next = ctr;
        endcase
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with per-entry 2-bit direction
// counters. Lookup result is registered (one cycle latency) and reads the
// table contents as they were before any same-edge update or flush.
module btb_predictor
    import btb_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEFAULT,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        lookup_valid,
    input  logic [31:0] pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    output logic        pred_valid,
    output logic        btb_found,
    output logic [31:0] btb_target,
    output logic        branch_prediction
);

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [29:0]      lk_tag;
    logic [29:0]      upd_tag;

    btb_entry_t entry_rd [ENTRIES];

    logic        lk_hit;
    logic [31:0] lk_target;
    ctr_e        lk_ctr;
    logic        upd_hit;
    ctr_e        upd_ctr;
    ctr_e        upd_ctr_next;

    logic        pred_valid_reg;
    logic        btb_found_reg;
    logic [31:0] btb_target_reg;
    logic        branch_prediction_reg;

    assign lk_idx  = IDX_W'(pc_index(pc, IDX_W));
    assign lk_tag  = pc_tag(pc, IDX_W);
    assign upd_idx = IDX_W'(pc_index(upd_pc, IDX_W));
    assign upd_tag = pc_tag(upd_pc, IDX_W);

    assign lk_hit    = entry_rd[lk_idx].valid && (entry_rd[lk_idx].tag == lk_tag);
    assign lk_target = entry_rd[lk_idx].target;
    assign lk_ctr    = entry_rd[lk_idx].ctr;

    assign upd_hit = entry_rd[upd_idx].valid && (entry_rd[upd_idx].tag == upd_tag);
    assign upd_ctr = entry_rd[upd_idx].ctr;

    // Only one entry is written per cycle, so one counter stepper suffices.
    sat_counter2 u_sat_counter2 (
        .ctr      (upd_ctr),
        .taken    (upd_taken),
        .ctr_next (upd_ctr_next)
    );

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            btb_entry_t entry_reg;
            logic       sel;

            assign sel = upd_valid && (upd_idx == IDX_W'(gi));

            // Entry state: reset > flush > update (train on hit, allocate on taken miss).
            always_ff @(posedge clk) begin
                if (!reset) begin
                    entry_reg.valid  <= 1'b0;
                    entry_reg.tag    <= '0;
                    entry_reg.target <= '0;
                    entry_reg.ctr    <= CTR_WNT;
                end else if (flush) begin
                    entry_reg.valid <= 1'b0;
                end else if (sel) begin
                    if (upd_hit) begin
                        entry_reg.ctr <= upd_ctr_next;
                        if (upd_taken) begin
                            entry_reg.target <= upd_target;
                        end
                    end else if (upd_taken) begin
                        entry_reg.valid  <= 1'b1;
                        entry_reg.tag    <= upd_tag;
                        entry_reg.target <= upd_target;
                        entry_reg.ctr    <= CTR_WT;
                    end
                end
            end

            assign entry_rd[gi] = entry_reg;
        end
    endgenerate

    // Registered lookup result; all outputs forced to zero when no lookup.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pred_valid_reg        <= 1'b0;
            btb_found_reg         <= 1'b0;
            btb_target_reg        <= '0;
            branch_prediction_reg <= 1'b0;
        end else begin
            pred_valid_reg        <= lookup_valid;
            btb_found_reg         <= lookup_valid && lk_hit;
            btb_target_reg        <= (lookup_valid && lk_hit) ? lk_target : 32'h0;
            branch_prediction_reg <= lookup_valid && lk_hit && lk_ctr[1];
        end
    end

    assign pred_valid        = pred_valid_reg;
    assign btb_found         = btb_found_reg;
    assign btb_target        = btb_target_reg;
    assign branch_prediction = branch_prediction_reg;

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed scenarios with literal
// expectations plus randomized traffic against a table-level model.
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic [31:0] upd_target = 32'h0;
    logic        upd_taken = 1'b0;
    logic        pred_valid;
    logic        btb_found;
    logic [31:0] btb_target;
    logic        branch_prediction;

    btb_predictor #(.ENTRIES(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .lookup_valid      (lookup_valid),
        .pc                (pc),
        .upd_valid         (upd_valid),
        .upd_pc            (upd_pc),
        .upd_target        (upd_target),
        .upd_taken         (upd_taken),
        .pred_valid        (pred_valid),
        .btb_found         (btb_found),
        .btb_target        (btb_target),
        .branch_prediction (branch_prediction)
    );

    always #5 clk = ~clk;

    // Reference table: 16 slots, plain integers.
    bit          m_valid  [16];
    int unsigned m_tag    [16];
    int unsigned m_target [16];
    int          m_ctr    [16];

    logic        exp_pv = 1'b0;
    logic        exp_found = 1'b0;
    logic [31:0] exp_tgt = 32'h0;
    logic        exp_pred = 1'b0;

    bit          chk_en = 1'b0;
    string       lit_name = "";
    logic        lit_pv, lit_found, lit_pred;
    logic [31:0] lit_tgt;
    int          cyc = 0;

    int num_checks = 0;
    int num_errors = 0;

    // Apply one clock edge to the model using the inputs just sampled.
    task automatic model_edge();
        int unsigned li, ui, lt, ut;
        bit hit;
        li = (pc >> 2) % 16;
        lt = pc >> 6;
        ui = (upd_pc >> 2) % 16;
        ut = upd_pc >> 6;
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = 1;
            end
            exp_pv = 0; exp_found = 0; exp_tgt = 0; exp_pred = 0;
            return;
        end
        hit       = lookup_valid && m_valid[li] && (m_tag[li] == lt);
        exp_pv    = lookup_valid;
        exp_found = hit;
        exp_tgt   = hit ? m_target[li] : 32'h0;
        exp_pred  = hit && (m_ctr[li] >= 2);
        if (flush) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 0;
        end else if (upd_valid) begin
            if (m_valid[ui] && m_tag[ui] == ut) begin
                if (upd_taken) begin
                    m_ctr[ui]    = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
                    m_target[ui] = upd_target;
                end else begin
                    m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
                end
            end else if (upd_taken) begin
                m_valid[ui]  = 1;
                m_tag[ui]    = ut;
                m_target[ui] = upd_target;
                m_ctr[ui]    = 2;
            end
        end
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        num_checks++;
        if (got !== want) begin
            num_errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
        end
    endtask

    // Single compare process: model every cycle, literal pins when requested.
    always @(negedge clk) begin
        if (chk_en) begin
            $display("cyc %0d rst=%b fl=%b lk=%b pc=%h up=%b upc=%h ut=%h tk=%b -> pv=%b f=%b t=%h p=%b",
                     cyc, reset, flush, lookup_valid, pc, upd_valid, upd_pc, upd_target,
                     upd_taken, pred_valid, btb_found, btb_target, branch_prediction);
            check("pred_valid", {31'b0, pred_valid}, {31'b0, exp_pv});
            check("btb_found", {31'b0, btb_found}, {31'b0, exp_found});
            check("btb_target", btb_target, exp_tgt);
            check("branch_prediction", {31'b0, branch_prediction}, {31'b0, exp_pred});
            if (lit_name != "") begin
                check({lit_name, ".pv"}, {31'b0, pred_valid}, {31'b0, lit_pv});
                check({lit_name, ".found"}, {31'b0, btb_found}, {31'b0, lit_found});
                check({lit_name, ".target"}, btb_target, lit_tgt);
                check({lit_name, ".pred"}, {31'b0, branch_prediction}, {31'b0, lit_pred});
            end
        end
    end

    task automatic do_cycle(input logic rst_n, input logic fl, input logic lv,
                            input logic [31:0] p, input logic uv, input logic [31:0] up,
                            input logic [31:0] ut, input logic tk,
                            input string nm = "", input logic e_pv = 1'b0,
                            input logic e_f = 1'b0, input logic [31:0] e_t = 32'h0,
                            input logic e_p = 1'b0);
        reset = rst_n; flush = fl; lookup_valid = lv; pc = p;
        upd_valid = uv; upd_pc = up; upd_target = ut; upd_taken = tk;
        @(posedge clk);
        model_edge();
        lit_name = nm; lit_pv = e_pv; lit_found = e_f; lit_tgt = e_t; lit_pred = e_p;
        chk_en = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic lookup(input logic [31:0] p, input string nm, input logic e_f,
                          input logic [31:0] e_t, input logic e_p);
        do_cycle(1, 0, 1, p, 0, 0, 0, 0, nm, 1, e_f, e_t, e_p);
    endtask

    task automatic update(input logic [31:0] up, input logic [31:0] ut, input logic tk);
        do_cycle(1, 0, 0, 0, 1, up, ut, tk);
    endtask

    initial begin
        // Reset
        do_cycle(0, 0, 1, 32'h100, 1, 32'h100, 32'h200, 1, "reset0", 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, "reset1", 0, 0, 0, 0);

        // Cold lookup misses
        lookup(32'h100, "cold", 0, 32'h0, 0);

        // Allocate then hit with weak-taken counter
        update(32'h100, 32'h200, 1);
        lookup(32'h100, "alloc", 1, 32'h200, 1);

        // Train down to strong-NT, saturate, then one taken step
        update(32'h100, 32'h999, 0);
        update(32'h100, 32'h999, 0);
        update(32'h100, 32'h999, 0);
        lookup(32'h100, "sat_low", 1, 32'h200, 0);
        update(32'h100, 32'h200, 1);
        lookup(32'h100, "wnt", 1, 32'h200, 0);
        num_checks++;
        if (m_ctr[0] != 1) begin
            num_errors++;
            $display("FAIL model_ctr got=%0d want=1", m_ctr[0]);
        end

        // Alias eviction
        update(32'h140, 32'h300, 1);
        lookup(32'h100, "alias_old", 0, 32'h0, 0);
        lookup(32'h140, "alias_new", 1, 32'h300, 1);

        // Same-cycle lookup and first allocation: read-before-write
        do_cycle(1, 0, 1, 32'h104, 1, 32'h104, 32'h500, 1, "rbw", 1, 0, 0, 0);
        lookup(32'h104, "rbw_next", 1, 32'h500, 1);

        // Flush with concurrent update; lookup during flush still sees old state
        do_cycle(1, 1, 1, 32'h140, 1, 32'h180, 32'h600, 1, "flush_cyc", 1, 1, 32'h300, 1);
        lookup(32'h140, "flush_old", 0, 32'h0, 0);
        lookup(32'h180, "flush_upd", 0, 32'h0, 0);

        // Reset mid-run discards entries and in-flight results
        update(32'h1C0, 32'h700, 1);
        lookup(32'h1C0, "pre_rst", 1, 32'h700, 1);
        do_cycle(0, 0, 1, 32'h1C0, 0, 0, 0, 0, "mid_rst", 0, 0, 0, 0);
        lookup(32'h1C0, "post_rst", 0, 32'h0, 0);

        // Randomized traffic over a small tag pool so hits and aliasing are common
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] rp, rup, rut;
            logic rrst, rfl, rlv, ruv, rtk;
            rp   = (($urandom_range(0, 3) + 4) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            rup  = (($urandom_range(0, 3) + 4) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            rut  = $urandom;
            rrst = ($urandom_range(0, 99) != 0);
            rfl  = ($urandom_range(0, 49) == 0);
            rlv  = ($urandom_range(0, 9) < 8);
            ruv  = ($urandom_range(0, 9) < 7);
            rtk  = ($urandom_range(0, 9) < 6);
            do_cycle(rrst, rfl, rlv, rp, ruv, rup, rut, rtk);
        end

        chk_en = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Branch target buffer and 2-bit direction predictor feeding the branch detector stage. Looks up the fetch PC and, one cycle later, supplies `btb_found`, `btb_target` and `branch_prediction` for that PC. Resolved branches write back through an update port to allocate entries, refresh targets and train the per-entry saturating counters. Direct-mapped, registered lookup output, single write per cycle.

## Interface

- `ENTRIES`, 16, number of BTB entries; power of two, 4..256
- `IDX_W`, $clog2(ENTRIES), index width; derived, do not override
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low; sampled on `clk` rising edge
- `flush`  in  1  invalidate all entries this cycle
- `lookup_valid`  in  1  fetch PC present on `pc`
- `pc`  in  32  fetch PC; bits [1:0] ignored
- `upd_valid`  in  1  resolved-branch update present
- `upd_pc`  in  32  PC of resolved branch
- `upd_target`  in  32  resolved target address
- `upd_taken`  in  1  resolved direction
- `pred_valid`  out  1  lookup result valid this cycle
- `btb_found`  out  1  tag hit on a valid entry
- `btb_target`  out  32  stored target on hit, 32'h0 on miss
- `branch_prediction`  out  1  predicted taken: hit and counter[1]==1

## Operation

- Index = `pc[IDX_W+1:2]`; tag = `pc[31:IDX_W+2]`; same split for `upd_pc`.
- Entry: valid, tag, target[31:0], ctr[1:0]. Encodings: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup: at edge with `lookup_valid`=1, register hit = valid && tag match; `btb_target` = target on hit else 0; `branch_prediction` = hit && ctr[1]. `lookup_valid`=0 -> `pred_valid`=0, other outputs 0.
- Update, hit on `upd_pc`: ctr saturating +1 if `upd_taken` else -1 (00 stays 00, 11 stays 11); if taken, target <= `upd_target`; not-taken keeps old target.
- Update, miss, taken: allocate/overwrite slot: valid=1, tag, target=`upd_target`, ctr=10.
- Update, miss, not-taken: no state change.
- `flush`=1: all valid bits cleared; update in the same cycle is dropped.
- Priority: reset > flush > update.
- Lookup and update in same cycle, same index: lookup returns pre-update contents (read-before-write). Same for lookup coincident with flush.

## Timing

- Lookup latency 1 cycle: `pc` sampled edge N, outputs valid after edge N, held until edge N+1.
- Update visible to lookups sampled at edge N+1 or later when applied at edge N.
- Throughput: one lookup and one update per cycle, no stalls, no backpressure.
- Reset (`reset`=0 at edge): all valid bits 0, counters 01, `pred_valid`=0, `btb_found`=0, `btb_target`=32'h0, `branch_prediction`=0. Lookup/update in that cycle ignored. Reset mid-operation discards all in-flight results.
- Targets and counters not cleared by flush; only valid bits.

## Structure

- Package `btb_pkg`: counter encodings (CTR_SNT/WNT/WT/ST), default ENTRIES, entry struct type, index/tag extraction functions.
- Sub-module `sat_counter2`: combinational 2-bit saturating next-state (in: ctr, taken; out: ctr_next). Instantiated once, on the update path.
- Storage as flat registers (ENTRIES ≤ 256); no SRAM macro.

## Test plan

- Reset then lookup `pc`=0x100 -> next cycle `pred_valid`=1, `btb_found`=0, `btb_target`=0, `branch_prediction`=0.
- Update 0x100 taken target 0x200, then lookup 0x100 -> found=1, target=0x200, prediction=1 (ctr 10).
- Three not-taken updates on 0x100 after allocation -> ctr 10->01->00->00; lookup gives found=1, prediction=0, target 0x200; one taken update -> ctr 01, prediction still 0.
- Alias: 0x100 and 0x140 (ENTRIES=16) share index; taken update 0x140 target 0x300 evicts; lookup 0x100 -> found=0; lookup 0x140 -> target 0x300.
- Same-cycle lookup 0x100 and first taken update 0x100 -> that lookup found=0; lookup next cycle found=1.
- `flush` with concurrent taken update on 0x180 -> lookups of 0x100 and 0x180 miss; mid-run `reset`=0 -> all outputs 0 next cycle, prior entries miss.
